// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Pipeline-stage register with valid/ready handshake, a
//                one-entry skid buffer, pipeline flush and exception
//                redirect. Carries {pc, ir, exc, bd} between CPU stages.
//                in_ready is decoded from registered state only, so it has
//                no combinational path from out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int          EXC_W      = 5,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] FLUSH_PC   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_ir,
    input  logic [EXC_W-1:0] in_exc,
    input  logic             in_bd,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_ir,
    output logic [EXC_W-1:0] out_exc,
    output logic             out_bd,

    input  logic             flush,
    input  logic             req,
    output logic [1:0]       occupancy
);

    // Occupancy encodings
    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    // Head-register load source
    localparam logic [2:0] c_HEAD_HOLD    = 3'd0;
    localparam logic [2:0] c_HEAD_IN      = 3'd1;
    localparam logic [2:0] c_HEAD_SKID    = 3'd2;
    localparam logic [2:0] c_HEAD_HANDLER = 3'd3;
    localparam logic [2:0] c_HEAD_FLUSH   = 3'd4;

    // Registered state
    logic [1:0]       r_occ;
    logic [31:0]      r_head_pc;
    logic [31:0]      r_head_ir;
    logic [EXC_W-1:0] r_head_exc;
    logic             r_head_bd;
    logic [31:0]      r_skid_pc;
    logic [31:0]      r_skid_ir;
    logic [EXC_W-1:0] r_skid_exc;
    logic             r_skid_bd;

    // Next-state decode
    logic             w_in_fire;
    logic             w_out_fire;
    logic [1:0]       w_occ_next;
    logic [2:0]       w_head_sel;
    logic             w_skid_load;
    logic             w_skid_clear;

    // Handshake outputs come straight from registered occupancy
    assign in_ready   = (r_occ != c_OCC_FULL);
    assign out_valid  = (r_occ != c_OCC_EMPTY);
    assign occupancy  = r_occ;

    assign out_pc     = r_head_pc;
    assign out_ir     = r_head_ir;
    assign out_exc    = r_head_exc;
    assign out_bd     = r_head_bd;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Decide occupancy change and data movement; req beats flush beats handshake
    always_comb begin
        w_occ_next   = r_occ;
        w_head_sel   = c_HEAD_HOLD;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;

        if (req) begin
            // Redirect: everything held is dropped, a handler bubble remains
            w_occ_next   = c_OCC_ONE;
            w_head_sel   = c_HEAD_HANDLER;
            w_skid_clear = 1'b1;
        end else if (flush) begin
            w_occ_next   = c_OCC_EMPTY;
            w_head_sel   = c_HEAD_FLUSH;
            w_skid_clear = 1'b1;
        end else begin
            case (r_occ)
                c_OCC_EMPTY: begin
                    if (w_in_fire) begin
                        w_occ_next = c_OCC_ONE;
                        w_head_sel = c_HEAD_IN;
                    end
                end
                c_OCC_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_head_sel = c_HEAD_IN;
                    end else if (w_out_fire) begin
                        w_occ_next = c_OCC_EMPTY;
                    end else if (w_in_fire) begin
                        // Downstream stalled: absorb this entry into the skid slot
                        w_occ_next  = c_OCC_FULL;
                        w_skid_load = 1'b1;
                    end
                end
                c_OCC_FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (w_out_fire) begin
                        w_occ_next = c_OCC_ONE;
                        w_head_sel = c_HEAD_SKID;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty
                    w_occ_next = c_OCC_EMPTY;
                end
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= c_OCC_EMPTY;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    // Head entry: drives out_* directly and holds its value when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_pc  <= FLUSH_PC;
            r_head_ir  <= 32'd0;
            r_head_exc <= '0;
            r_head_bd  <= 1'b0;
        end else begin
            case (w_head_sel)
                c_HEAD_IN: begin
                    r_head_pc  <= in_pc;
                    r_head_ir  <= in_ir;
                    r_head_exc <= in_exc;
                    r_head_bd  <= in_bd;
                end
                c_HEAD_SKID: begin
                    r_head_pc  <= r_skid_pc;
                    r_head_ir  <= r_skid_ir;
                    r_head_exc <= r_skid_exc;
                    r_head_bd  <= r_skid_bd;
                end
                c_HEAD_HANDLER: begin
                    r_head_pc  <= HANDLER_PC;
                    r_head_ir  <= 32'd0;
                    r_head_exc <= '0;
                    r_head_bd  <= 1'b0;
                end
                c_HEAD_FLUSH: begin
                    r_head_pc  <= FLUSH_PC;
                    r_head_ir  <= 32'd0;
                    r_head_exc <= '0;
                    r_head_bd  <= 1'b0;
                end
                default: begin
                    r_head_pc  <= r_head_pc;
                    r_head_ir  <= r_head_ir;
                    r_head_exc <= r_head_exc;
                    r_head_bd  <= r_head_bd;
                end
            endcase
        end
    end

    // Skid entry: second-in-line while downstream is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_pc  <= 32'd0;
            r_skid_ir  <= 32'd0;
            r_skid_exc <= '0;
            r_skid_bd  <= 1'b0;
        end else if (w_skid_clear) begin
            r_skid_pc  <= 32'd0;
            r_skid_ir  <= 32'd0;
            r_skid_exc <= '0;
            r_skid_bd  <= 1'b0;
        end else if (w_skid_load) begin
            r_skid_pc  <= in_pc;
            r_skid_ir  <= in_ir;
            r_skid_exc <= in_exc;
            r_skid_bd  <= in_bd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Scoreboard bench for pipe_skid_reg. The reference model is
//                an ordered queue of in-flight entries (max two); flush
//                empties it, req replaces it with the handler entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int          EXC_W      = 5;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] FLUSH_PC   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      ir;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } entry_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_ir;
    logic [EXC_W-1:0] in_exc;
    logic             in_bd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_ir;
    logic [EXC_W-1:0] out_exc;
    logic             out_bd;
    logic             flush;
    logic             req;
    logic [1:0]       occupancy;

    pipe_skid_reg #(
        .EXC_W      (EXC_W),
        .HANDLER_PC (HANDLER_PC),
        .FLUSH_PC   (FLUSH_PC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ir     (in_ir),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ir    (out_ir),
        .out_exc   (out_exc),
        .out_bd    (out_bd),
        .flush     (flush),
        .req       (req),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight entries in arrival order
    entry_t exp_q[$];
    int     exp_occ;
    int     n_checks;
    int     n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic [31:0] pc, input logic [31:0] ir,
                                  input logic [EXC_W-1:0] exc, input logic bd);
        entry_t e;
        e.pc = pc; e.ir = ir; e.exc = exc; e.bd = bd;
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, update the model after the edge
    task automatic cycle(input bit iv, input entry_t d, input bit ordy,
                         input bit fl, input bit rq);
        entry_t h;
        @(negedge clk);
        in_valid  = iv;
        in_pc     = d.pc;
        in_ir     = d.ir;
        in_exc    = d.exc;
        in_bd     = d.bd;
        out_ready = ordy;
        flush     = fl;
        req       = rq;
        if (iv && exp_occ != 2 && !fl && !rq) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (rq) begin
            exp_q.delete();
            h = mk(HANDLER_PC, 32'd0, '0, 1'b0);
            exp_q.push_back(h);
        end else if (fl) begin
            exp_q.delete();
        end
        exp_occ = exp_q.size();
    endtask

    // Monitor: checks handshake state and pops the scoreboard on each out_fire
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #2;
            check("occupancy", 64'(occupancy), 64'(exp_occ));
            check("out_valid", 64'(out_valid), 64'(exp_occ != 0));
            check("in_ready",  64'(in_ready),  64'(exp_occ != 2));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got out_pc %0h expected no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc",  64'(out_pc),  64'(e.pc));
                    check("sb_ir",  64'(out_ir),  64'(e.ir));
                    check("sb_exc", 64'(out_exc), 64'(e.exc));
                    check("sb_bd",  64'(out_bd),  64'(e.bd));
                end
            end
        end
    end

    entry_t idle;
    entry_t a, b;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_occ  = 0;
        idle     = mk(32'hDEAD_0000, 32'h0, '0, 1'b0);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'd0;
        in_ir     = 32'd0;
        in_exc    = '0;
        in_bd     = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        req       = 1'b0;

        // Reset state
        #12;
        check("rst_occ",    64'(occupancy), 64'd0);
        check("rst_ovalid", 64'(out_valid), 64'd0);
        check("rst_iready", 64'(in_ready),  64'd1);
        check("rst_pc",     64'(out_pc),    64'(FLUSH_PC));
        check("rst_ir",     64'(out_ir),    64'd0);
        check("rst_exc",    64'(out_exc),   64'd0);
        check("rst_bd",     64'(out_bd),    64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Streaming at full rate
        for (int i = 0; i < 3; i++) begin
            a = mk(32'h3000 + 32'(4 * i), 32'h1100_0000 + 32'(i), 5'(i), i[0]);
            cycle(1'b1, a, 1'b1, 1'b0, 1'b0);
            check("stream_pc",  64'(out_pc),    64'(32'h3000 + 32'(4 * i)));
            check("stream_occ", 64'(occupancy), 64'd1);
        end
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Backpressure into skid, then hold stability
        a = mk(32'h3000, 32'hAAAA_0001, 5'd3, 1'b1);
        b = mk(32'h3004, 32'hBBBB_0002, 5'd7, 1'b0);
        cycle(1'b1, a, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
        check("skid_occ",    64'(occupancy), 64'd2);
        check("skid_iready", 64'(in_ready),  64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, mk(32'h3F00, 32'h0, '0, 1'b0), 1'b0, 1'b0, 1'b0);
            check("hold_pc",  64'(out_pc),  64'(a.pc));
            check("hold_ir",  64'(out_ir),  64'(a.ir));
            check("hold_exc", 64'(out_exc), 64'(a.exc));
            check("hold_bd",  64'(out_bd),  64'(a.bd));
        end
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0);
        check("drain_pc", 64'(out_pc), 64'(b.pc));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Flush with occ = 2 and a live input
        cycle(1'b1, mk(32'h3020, 32'h20, 5'd1, 1'b0), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h3024, 32'h24, 5'd2, 1'b1), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h3010, 32'h10, 5'd0, 1'b0), 1'b0, 1'b1, 1'b0);
        check("flush_occ",    64'(occupancy), 64'd0);
        check("flush_ovalid", 64'(out_valid), 64'd0);
        check("flush_pc",     64'(out_pc),    64'(FLUSH_PC));
        for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Exception redirect together with flush
        cycle(1'b1, mk(32'h3030, 32'h30, 5'd4, 1'b1), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h3034, 32'h34, 5'd0, 1'b0), 1'b0, 1'b1, 1'b1);
        check("req_pc",     64'(out_pc),    64'(HANDLER_PC));
        check("req_ir",     64'(out_ir),    64'd0);
        check("req_exc",    64'(out_exc),   64'd0);
        check("req_bd",     64'(out_bd),    64'd0);
        check("req_ovalid", 64'(out_valid), 64'd1);
        check("req_occ",    64'(occupancy), 64'd1);
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Redirect with both entries held
        cycle(1'b1, mk(32'h3040, 32'h40, 5'd9, 1'b0), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h3044, 32'h44, 5'd8, 1'b1), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b0, 1'b0, 1'b1);
        check("req2_pc",  64'(out_pc),    64'(HANDLER_PC));
        check("req2_occ", 64'(occupancy), 64'd1);
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with occ = 2
        cycle(1'b1, mk(32'h3050, 32'h50, 5'd1, 1'b0), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h3054, 32'h54, 5'd2, 1'b0), 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        exp_q.delete();
        exp_occ = 0;
        #1;
        check("arst_occ",    64'(occupancy), 64'd0);
        check("arst_ovalid", 64'(out_valid), 64'd0);
        check("arst_pc",     64'(out_pc),    64'(FLUSH_PC));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            a = mk($urandom, $urandom, 5'($urandom), 1'($urandom));
            cycle($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1, 1'b0, 1'b0);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer, a pipeline flush, and exception redirect. It sits between any two CPU pipeline stages, such as F/D, D/E, E/M or M/W. It carries PC, instruction word, exception code and branch-delay flag. Stall is expressed through ready/valid handshake backpressure instead of a hold-enable input, and `in_ready` has no combinational dependence on `out_ready`.

## Interface
- `EXC_W`, 5, width of the exception-code field
- `HANDLER_PC`, 32'h0000_4180, PC loaded on exception redirect
- `FLUSH_PC`, 32'h0000_0000, PC value written on reset and flush
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  upstream presents an entry
- `in_ready`  out  1  this stage can accept an entry
- `in_pc`  in  32  upstream PC
- `in_ir`  in  32  upstream instruction word
- `in_exc`  in  EXC_W  upstream exception code
- `in_bd`  in  1  upstream branch-delay flag
- `out_valid`  out  1  entry presented downstream
- `out_ready`  in  1  downstream accepts the entry
- `out_pc` / `out_ir` / `out_exc` / `out_bd`  out  32/32/EXC_W/1  head-entry fields
- `flush`  in  1  kill all held entries and insert a bubble
- `req`  in  1  exception redirect; overrides `flush`
- `occupancy`  out  2  number of valid entries held (0..2)

## Operation
- Storage: a head entry (drives `out_*`) and a skid entry. Each entry holds {pc, ir, exc, bd}.
- Handshakes:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
- `in_ready = (occupancy != 2)`. It is decoded from registered state only.
- `out_valid = (occupancy != 0)`. The `out_*` fields are driven directly from head registers.
- Per-cycle priority: `req` > `flush` > normal handshake.
- `req` = 1:
  - Next state: head = {HANDLER_PC, 0, 0, 0}, occupancy = 1, skid cleared.
  - Any `in_fire` in that cycle is discarded.
  - Any `out_fire` in that cycle still counts as consumed downstream.
- `flush` = 1 (and `req` = 0):
  - Next state: head = {FLUSH_PC, 0, 0, 0}, skid cleared, occupancy = 0.
  - Input in that cycle is discarded.
- Normal operation, by occupancy:
  - occ 0, `in_fire`: the input goes to head; occ becomes 1.
  - occ 1, `in_fire & out_fire`: the input replaces head; occ stays 1.
  - occ 1, `out_fire` only: occ becomes 0.
  - occ 1, `in_fire` only: the input goes to skid; occ becomes 2.
  - occ 2, `out_fire`: head takes the skid contents; occ becomes 1. No input is possible because `in_ready` = 0.
  - Otherwise: hold.
- Ordering: entries leave strictly in arrival order. No entry is lost or duplicated.
- When `out_valid` = 0, `out_*` hold the last head value. Downstream must ignore them.
- The block performs no arithmetic and no field modification. Payload passes bit-exact.

## Timing
- Reset (async assert, sync-safe release):
  - occupancy = 0, `out_valid` = 0, `in_ready` = 1.
  - `out_pc` = FLUSH_PC, `out_ir` = 0, `out_exc` = 0, `out_bd` = 0.
- Latency: an entry accepted at edge N is on `out_*` with `out_valid` = 1 after edge N. This is 1 cycle, with no bypass.
- Throughput: 1 entry/cycle while `out_ready` = 1.
- Backpressure:
  - When `out_ready` drops with occ = 1, one more input is absorbed into skid.
  - `in_ready` falls on the following cycle.
- Stability: while `out_valid` = 1 and `out_ready` = 0, `out_*` are stable every cycle, except when `req` or `flush` is asserted.
- Boundary cases:
  - `req` and `flush` together: `req` result.
  - `req` with occ = 2: both entries are dropped; only the handler bubble remains.
  - Reset asserted mid-transfer: state clears immediately, without waiting for the clock.

## Test plan
- Reset and stream:
  - Stimulus: release `rst_n`; drive PCs 0x3000, 0x3004, 0x3008 on consecutive cycles with `out_ready` = 1.
  - Required response: `out_pc` shows each value one cycle later; occupancy stays 1.
- Backpressure/skid:
  - Stimulus: with occ = 1 (head 0x3000), drop `out_ready` and present 0x3004.
  - Required response: occ = 2 and `in_ready` = 0 next cycle.
  - Stimulus: raise `out_ready`.
  - Required response: 0x3000 then 0x3004 out in order.
- Hold stability:
  - Stimulus: `out_ready` = 0 for 5 cycles with occ = 2.
  - Required response: `out_pc`/`out_ir`/`out_exc`/`out_bd` unchanged every cycle.
- Flush:
  - Stimulus: occ = 2; pulse `flush` while `in_valid` = 1 with PC 0x3010.
  - Required response: next cycle occ = 0, `out_valid` = 0, `out_pc` = 0; 0x3010 never appears.
- Exception redirect:
  - Stimulus: occ = 1, head `in_exc` = 5'd4; pulse `req` and `flush` together.
  - Required response: next cycle `out_pc` = 0x00004180, `out_ir` = 0, `out_exc` = 0, `out_bd` = 0, `out_valid` = 1, occ = 1.
- Async reset:
  - Stimulus: drop `rst_n` mid-cycle with occ = 2.
  - Required response: `out_valid` = 0 and occupancy = 0 before the next clock edge.
